// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and baud divisor helper for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Rounded clocks-per-bit so odd clock/baud ratios land on the nearest integer.
  function automatic int f_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_word_assembler_if.sv
// rtl/uart_rx_word_assembler_if.sv - word-side strobes and data of the UART word assembler
interface uart_rx_word_assembler_if;
  logic        valid;
  logic [31:0] data;
  logic        frame_err;
  logic        drop;

  modport master (output valid, data, frame_err, drop);
  modport slave  (input  valid, data, frame_err, drop);
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: rxd synchroniser, edge detect and framing FSM
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int P_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       idle,
  output logic       fall
);

  localparam int P_HALF = P_DIV / 2;
  localparam int CW     = $clog2(P_DIV + 1);

  logic          sync1, rx_s, rx_d;
  rx_state_e     state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_done;

  // Preset high so reset looks like an idle line and never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  assign fall      = rx_d & ~rx_s;
  assign idle      = (state == IDLE);
  assign byte_data = shreg;

  always_comb begin
    baud_done = (state == START) ? (baud_cnt == CW'(P_HALF - 1))
                                 : (baud_cnt == CW'(P_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (baud_done) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (baud_done && bit_cnt == 3'd7) state_nxt = STOP;
      STOP: begin
        if (baud_done) begin
          if (rx_s) begin
            byte_vld  = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (baud_done) begin
      baud_cnt <= '0;
      if (state == DATA) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// rtl/uart_rx_word_assembler.sv - packs received UART bytes into 32-bit words with idle-timeout discard
module uart_rx_word_assembler
  import uart_pkg::*;
#(
  parameter int P_CLK_HZ       = 148500000,
  parameter int P_BAUD         = 115200,
  parameter int P_TIMEOUT_BITS = 40
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_uart_rxd,
  uart_rx_word_assembler_if.master  word
);

  localparam int P_DIV = f_div(P_CLK_HZ, P_BAUD);
  localparam int P_TO  = P_TIMEOUT_BITS * P_DIV;
  localparam int TW    = $clog2(P_TO + 1);

  logic          byte_vld, frame_err, idle, fall;
  logic [7:0]    byte_data;
  logic [1:0]    cnt;
  logic [23:0]   lanes;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  uart_rx_byte #(.P_DIV(P_DIV)) u_byte (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .rxd       (i_uart_rxd),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .idle      (idle),
    .fall      (fall)
  );

  // A start edge in the expiry cycle suppresses the drop: the word is still alive.
  assign to_hit = idle && (cnt != 2'd0) && !fall && (to_cnt == TW'(P_TO - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word.valid     <= 1'b0;
      word.data      <= '0;
      word.frame_err <= 1'b0;
      word.drop      <= 1'b0;
      cnt            <= '0;
      lanes          <= '0;
    end else begin
      word.valid     <= 1'b0;
      word.frame_err <= frame_err;
      word.drop      <= 1'b0;
      if (byte_vld) begin
        case (cnt)
          2'd0: lanes[7:0]   <= byte_data;
          2'd1: lanes[15:8]  <= byte_data;
          2'd2: lanes[23:16] <= byte_data;
          default: begin
            word.data  <= {byte_data, lanes};
            word.valid <= 1'b1;
          end
        endcase
        cnt <= cnt + 2'd1;
      end else if (to_hit) begin
        cnt       <= '0;
        word.drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   to_cnt <= '0;
    else if (!idle || cnt == 2'd0 || fall || to_hit) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + TW'(1);
  end

endmodule
